// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared widths, limits and conversion states for the score stage
package score_pkg;

    localparam int SCORE_W = 8;
    localparam int BCD_W   = 4;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_t;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 after the shift.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// rtl/bin2bcd_iter.sv - iterative 8-bit binary to 3-digit BCD converter, one bit per cycle
module bin2bcd_iter
    import score_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [SCORE_W-1:0] i_bin,
    output logic               o_busy,
    output logic               o_done,
    output logic [BCD_W-1:0]   o_hundreds,
    output logic [BCD_W-1:0]   o_tens,
    output logic [BCD_W-1:0]   o_ones
);

    conv_state_t          r_state;
    logic [SCORE_W-1:0]   r_snap;
    logic [3*BCD_W-1:0]   r_bcd;
    logic [2:0]           r_cnt;
    logic [BCD_W-1:0]     r_hundreds;
    logic [BCD_W-1:0]     r_tens;
    logic [BCD_W-1:0]     r_ones;
    logic [3*BCD_W-1:0]   w_adj;

    assign w_adj = {dabble_adj(r_bcd[11:8]), dabble_adj(r_bcd[7:4]), dabble_adj(r_bcd[3:0])};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_snap     <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_hundreds <= '0;
            r_tens     <= '0;
            r_ones     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_snap  <= i_bin;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {r_bcd, r_snap} <= {w_adj, r_snap} << 1;
                    r_cnt           <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Digits change only here so the display never sees a partial result.
                    r_hundreds <= r_bcd[11:8];
                    r_tens     <= r_bcd[7:4];
                    r_ones     <= r_bcd[3:0];
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);
    assign o_hundreds = r_hundreds;
    assign o_tens     = r_tens;
    assign o_ones     = r_ones;

endmodule

// File: rtl/score_tracker.sv
// rtl/score_tracker.sv - score accumulation, freeze, session high score and BCD conversion trigger
module score_tracker
    import score_pkg::*;
#(
    parameter logic [SCORE_W-1:0] POINTS_PER_FOOD = 8'd1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_food_eaten,
    input  logic               i_game_over,
    input  logic               i_new_game,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_high_score,
    output logic [BCD_W-1:0]   o_bcd_hundreds,
    output logic [BCD_W-1:0]   o_bcd_tens,
    output logic [BCD_W-1:0]   o_bcd_ones,
    output logic               o_bcd_busy
);

    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high_score;
    logic               r_frozen;
    logic [SCORE_W-1:0] r_last_conv;
    logic [SCORE_W-1:0] r_inflight;
    logic [SCORE_W:0]   w_sum;
    logic [SCORE_W-1:0] w_food_score;
    logic               w_start;
    logic               w_busy;
    logic               w_done;

    assign w_sum        = {1'b0, r_score} + {1'b0, POINTS_PER_FOOD};
    assign w_food_score = w_sum[SCORE_W] ? SCORE_MAX : w_sum[SCORE_W-1:0];
    assign w_start      = (r_score != r_last_conv);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_score      <= '0;
            r_high_score <= '0;
            r_frozen     <= 1'b0;
        end else if (i_new_game) begin
            r_score  <= '0;
            r_frozen <= 1'b0;
        end else if (i_game_over) begin
            r_frozen <= 1'b1;
            if (r_score > r_high_score) begin
                r_high_score <= r_score;
            end
        end else if (i_food_eaten && !r_frozen) begin
            r_score <= w_food_score;
        end
    end

    // The converter accepts a start only while idle, so the snapshot it took is mirrored here.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_conv <= '0;
            r_inflight  <= '0;
        end else begin
            if (w_start && !w_busy) begin
                r_inflight <= r_score;
            end
            if (w_done) begin
                r_last_conv <= r_inflight;
            end
        end
    end

    bin2bcd_iter u_bin2bcd (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_start),
        .i_bin      (r_score),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_hundreds (o_bcd_hundreds),
        .o_tens     (o_bcd_tens),
        .o_ones     (o_bcd_ones)
    );

    assign o_score      = r_score;
    assign o_high_score = r_high_score;
    assign o_bcd_busy   = w_busy;

endmodule

// File: tb/tb_score_tracker.sv
// tb/tb_score_tracker.sv - directed self-checking bench for score_tracker
module tb_score_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       food, game_over, new_game;
    logic       f10_food, f10_game_over, f10_new_game;
    logic [7:0] score, high_score, s10, h10;
    logic [3:0] hund, tens, ones, hund10, tens10, ones10;
    logic       busy, busy10;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    score_tracker #(.POINTS_PER_FOOD(8'd1)) u_dut1 (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_food_eaten   (food),
        .i_game_over    (game_over),
        .i_new_game     (new_game),
        .o_score        (score),
        .o_high_score   (high_score),
        .o_bcd_hundreds (hund),
        .o_bcd_tens     (tens),
        .o_bcd_ones     (ones),
        .o_bcd_busy     (busy)
    );

    score_tracker #(.POINTS_PER_FOOD(8'd10)) u_dut10 (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_food_eaten   (f10_food),
        .i_game_over    (f10_game_over),
        .i_new_game     (f10_new_game),
        .o_score        (s10),
        .o_high_score   (h10),
        .o_bcd_hundreds (hund10),
        .o_bcd_tens     (tens10),
        .o_bcd_ones     (ones10),
        .o_bcd_busy     (busy10)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_digits(input string tag, input logic [3:0] eh, input logic [3:0] et, input logic [3:0] eo);
        chk({tag, "_hund"}, {28'd0, hund}, {28'd0, eh});
        chk({tag, "_tens"}, {28'd0, tens}, {28'd0, et});
        chk({tag, "_ones"}, {28'd0, ones}, {28'd0, eo});
    endtask

    initial begin
        reset = 1'b1;
        food = 1'b0; game_over = 1'b0; new_game = 1'b0;
        f10_food = 1'b0; f10_game_over = 1'b0; f10_new_game = 1'b0;
        step(2);
        reset = 1'b0;

        // Reset state and quiet idle
        chk("rst_score", {24'd0, score}, 32'd0);
        chk("rst_high", {24'd0, high_score}, 32'd0);
        chk_digits("rst", 4'd0, 4'd0, 4'd0);
        chk("rst_score10", {24'd0, s10}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Saturation with 10 points per food
        f10_food = 1'b1;
        step(25);
        chk("sat_250", {24'd0, s10}, 32'd250);
        step();
        chk("sat_255", {24'd0, s10}, 32'd255);
        step();
        f10_food = 1'b0;
        chk("sat_hold", {24'd0, s10}, 32'd255);
        step(25);
        chk("sat_hund", {28'd0, hund10}, 32'd2);
        chk("sat_tens", {28'd0, tens10}, 32'd5);
        chk("sat_ones", {28'd0, ones10}, 32'd5);
        chk("sat_busy", {31'd0, busy10}, 32'd0);

        // Single food: score next cycle, digits 10 edges later, busy for 9 cycles
        food = 1'b1;
        step();
        food = 1'b0;
        chk("single_score", {24'd0, score}, 32'd1);
        chk("single_busy0", {31'd0, busy}, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("single_busy", {31'd0, busy}, (i < 10) ? 32'd1 : 32'd0);
            if (i == 9) chk("single_early", {28'd0, ones}, 32'd0);
        end
        chk_digits("single", 4'd0, 4'd0, 4'd1);

        // Freeze with a discarded simultaneous food, then high score retention
        food = 1'b1;
        step(36);
        chk("frz_37", {24'd0, score}, 32'd37);
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        food = 1'b0;
        chk("frz_score", {24'd0, score}, 32'd37);
        chk("frz_high", {24'd0, high_score}, 32'd37);
        food = 1'b1;
        step();
        food = 1'b0;
        chk("frz_ignore", {24'd0, score}, 32'd37);
        step(25);
        chk_digits("frz", 4'd0, 4'd3, 4'd7);
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk("ng_score", {24'd0, score}, 32'd0);
        food = 1'b1;
        step(12);
        food = 1'b0;
        chk("g2_score", {24'd0, score}, 32'd12);
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        chk("g2_high", {24'd0, high_score}, 32'd37);
        new_game = 1'b1;
        game_over = 1'b1;
        step();
        new_game = 1'b0;
        game_over = 1'b0;
        chk("ng_go_score", {24'd0, score}, 32'd0);
        chk("ng_go_high", {24'd0, high_score}, 32'd37);

        // Change mid-conversion: 99 -> 100 at edge k, 101 at edge k+4
        food = 1'b1;
        step(99);
        food = 1'b0;
        step(25);
        chk("mid_99", {24'd0, score}, 32'd99);
        chk_digits("mid_99", 4'd0, 4'd9, 4'd9);
        food = 1'b1;
        step();
        food = 1'b0;
        chk("mid_100", {24'd0, score}, 32'd100);
        step(3);
        food = 1'b1;
        step();
        food = 1'b0;
        chk("mid_101", {24'd0, score}, 32'd101);
        step(5);
        chk_digits("mid_k9", 4'd0, 4'd9, 4'd9);
        step();
        chk_digits("mid_k10", 4'd1, 4'd0, 4'd0);
        step(9);
        chk_digits("mid_k19", 4'd1, 4'd0, 4'd0);
        step();
        chk_digits("mid_k20", 4'd1, 4'd0, 4'd1);

        // new_game beats food, then reset during CONV
        new_game = 1'b1;
        food = 1'b1;
        step();
        new_game = 1'b0;
        food = 1'b0;
        chk("ng_food_score", {24'd0, score}, 32'd0);
        step(2);
        chk("conv_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_score", {24'd0, score}, 32'd0);
        chk("mrst_high", {24'd0, high_score}, 32'd0);
        chk_digits("mrst", 4'd0, 4'd0, 4'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_score10", {24'd0, s10}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
# score_tracker

Sequential score stage for the snake game: accumulates the 8-bit score on food events, freezes it on game over, keeps a session high score, and converts the live score to three BCD digits using an iterative double-dabble engine. It sits directly upstream of the decimal-to-hex display stage, which consumes its `score` and BCD digit outputs. It sits downstream of the game FSM, which supplies the event pulses.

## Interface
- `POINTS_PER_FOOD`, default 1: unsigned 8-bit increment applied per food event.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `food_eaten`  in  1: food event; each cycle it is high adds points once. Upstream drives single-cycle pulses.
- `game_over`  in  1: pulse; freezes the score and updates the high score.
- `new_game`  in  1: pulse; clears the score and unfreezes it.
- `score`  out  8: current score, binary.
- `high_score`  out  8: highest frozen score since reset.
- `bcd_hundreds`, `bcd_tens`, `bcd_ones`  out  4 each: BCD digits of the last converted score.
- `bcd_busy`  out  1: high while a conversion is in flight.

## Operation
- **Reset:** all outputs are 0. Internal state after reset:
  - `frozen` = 0
  - `last_conv` = 0
  - FSM in IDLE
- **Score update priority** (highest first; evaluated every cycle):
  1. `new_game`: score ← 0, frozen ← 0.
  2. `game_over`: frozen ← 1, score holds. high_score ← max(high_score, score), registered on the same edge.
  3. `food_eaten` && !frozen: score ← min(score + POINTS_PER_FOOD, 255). The sum is computed in 9 bits and saturates at 255, with no wrap-around.
  4. `food_eaten` while frozen is ignored.
- **Simultaneous events:**
  - `game_over` + `food_eaten` in the same cycle: the food is discarded, and high_score uses the pre-edge score.
  - `new_game` + `game_over`: `new_game` wins, and high_score is unchanged.
- **Conversion FSM states:**
  - **IDLE:** if `score != last_conv`, latch snap ← score, clear the 12-bit BCD shift register, set cnt ← 0, and go to CONV. Otherwise stay.
  - **CONV:** each cycle, add 3 to every BCD nibble that is ≥5, then shift {bcd, snap} left by 1. Increment cnt. After the 8th iteration (cnt = 7), go to DONE.
  - **DONE:** register the three nibbles onto the BCD outputs, set last_conv ← snap, and go to IDLE.
- `bcd_busy` is high in CONV and DONE.
- BCD outputs hold their previous value until DONE. The display never sees partial digits.
- **Score change mid-conversion:** the conversion finishes on the old snapshot. IDLE then detects the mismatch and restarts. There is no abort.
- **Reset mid-conversion:** the FSM returns to IDLE and all outputs return to 0 on the reset edge.

## Timing
- `score` and `high_score` are visible one cycle after the event edge.
- **Conversion latency:** if the score register changes at edge k, then:
  - IDLE latches at edge k+1.
  - Iterations complete on edges k+2 through k+9.
  - BCD outputs update at edge k+10.
- `bcd_busy` is high from after edge k+1 until edge k+10.
- **Back-to-back food pulses:** the worst case is one extra 10-cycle conversion after the last change.
- **Max hundreds digit:** 2. Digits never exceed 9.

## Structure
- **Shared package `score_pkg`:**
  - `SCORE_W` = 8 and `BCD_W` = 4.
  - `SCORE_MAX` = 255.
  - Conversion state enum {IDLE, CONV, DONE}.
- **Sub-module `bin2bcd_iter`:**
  - Owns snap, the BCD shift register, cnt and the FSM.
  - Interface: start/bin[7:0] in; busy and done/hundreds/tens/ones out.
- **`score_tracker`:**
  - Owns the score, frozen and high-score registers and the change detection.
  - Instantiates `bin2bcd_iter` once.

## Test plan
- **Reset then idle:** hold `reset` 2 cycles. Required: all outputs 0, `bcd_busy` 0 for 20 cycles.
- **Single food, POINTS_PER_FOOD = 1:** pulse `food_eaten` once. Required:
  - `score` = 1 the next cycle.
  - `bcd_ones` = 1 exactly 10 cycles after the score edge.
  - `bcd_busy` high for 9 cycles.
- **Saturation, POINTS_PER_FOOD = 10:**
  - 25 pulses: `score` = 250.
  - 26th pulse: `score` = 255.
  - 27th pulse: `score` stays 255.
  - Final digits 2/5/5.
- **Freeze and high score:** `score` = 37, pulse `game_over`. Required:
  - `high_score` = 37.
  - A later `food_eaten` leaves `score` at 37.
  - `new_game` sets `score` to 0.
  - A second game ending at 12 keeps `high_score` at 37.
- **Change mid-conversion:** from `score` = 99, pulse `food_eaten` at edges k and k+4. Required:
  - Digits first show 1/0/0 at edge k+10.
  - A reconversion then shows 1/0/1 at edge k+20.
- **Simultaneous events and reset mid-conversion:**
  - `new_game` + `food_eaten` in the same cycle: `score` = 0.
  - Assert `reset` during CONV: all outputs are 0 on the next edge and `bcd_busy` is 0.
